camera_frame_seq: RTL and testbench

CAMERA_FRAME_SEQ -- requirements
Module: camera_frame_seq

---
 rtl/camera_frame_seq.sv | 207 ++++++++++++++++++++
 tb/tb_camera_frame_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_frame_seq.sv
// rtl/camera_frame_seq.sv - ping-pong camera frame capture sequencer driving the camera config bus
module camera_frame_seq #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [30:0]               glob_cfg_i,
  input  logic [1:0]                datasize_i,
  input  logic [L2_AWIDTH_NOAL-1:0] buf0_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] buf1_addr_i,
  input  logic [TRANS_SIZE-1:0]     frame_size_i,
  input  logic [7:0]                num_frames_i,
  input  logic [7:0]                poll_gap_i,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      frame_buf_o,
  output logic [7:0]                frame_cnt_o,
  output logic                      done_o,
  output logic                      aborted_o
);

  typedef enum logic [3:0] {
    IDLE, WR_GLOB, WR_SADDR, WR_SIZE, WR_CFG,
    POLL_WAIT, POLL_RD, NEXT, CLR_CFG, DIS_GLOB
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        rwn;
    logic [4:0]  addr;
    logic [31:0] data;
  } bus_t;

  localparam logic [4:0] ADDR_SADDR = 5'h00;
  localparam logic [4:0] ADDR_SIZE  = 5'h01;
  localparam logic [4:0] ADDR_CFG   = 5'h02;
  localparam logic [4:0] ADDR_GLOB  = 5'h08;

  state_t     state;
  state_t     state_nx;
  state_t     poll_entry;
  logic       buf_idx;
  logic       idx_nx;
  logic       stop_req;
  logic       stop_pend;
  logic       bus_done;
  logic       bus_load;
  logic       status_idle;
  logic [7:0] poll_cnt;
  bus_t       bus_nx;
  logic       unused_rd;

  assign bus_done    = cfg_valid_o & cfg_ready_i;
  assign stop_pend   = stop_req | stop_i;
  assign status_idle = ~cfg_data_i[4] & ~cfg_data_i[5];
  assign poll_entry  = (poll_gap_i == 8'd0) ? POLL_RD : POLL_WAIT;
  assign unused_rd   = ^{cfg_data_i[31:6], cfg_data_i[3:0]};

  // Decision points divert to CLR_CFG when a stop is pending; bus states only move on acceptance.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start_i && !stop_i) state_nx = WR_GLOB;
      WR_GLOB:   if (bus_done) state_nx = stop_pend ? CLR_CFG : WR_SADDR;
      WR_SADDR:  if (bus_done) state_nx = stop_pend ? CLR_CFG : WR_SIZE;
      WR_SIZE:   if (bus_done) state_nx = stop_pend ? CLR_CFG : WR_CFG;
      WR_CFG:    if (bus_done) state_nx = stop_pend ? CLR_CFG : poll_entry;
      POLL_WAIT: begin
        if (stop_pend)            state_nx = CLR_CFG;
        else if (poll_cnt == 8'd0) state_nx = POLL_RD;
      end
      POLL_RD: begin
        if (bus_done) begin
          if (stop_pend)        state_nx = CLR_CFG;
          else if (status_idle) state_nx = NEXT;
          else                  state_nx = poll_entry;
        end
      end
      NEXT: begin
        if (stop_pend)
          state_nx = CLR_CFG;
        else if (num_frames_i != 8'd0 && frame_cnt_o == num_frames_i)
          state_nx = DIS_GLOB;
        else
          state_nx = WR_SADDR;
      end
      CLR_CFG:   if (bus_done) state_nx = DIS_GLOB;
      DIS_GLOB:  if (bus_done) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    idx_nx = buf_idx;
    if (state == IDLE && state_nx == WR_GLOB)
      idx_nx = 1'b0;
    else if (state == NEXT)
      idx_nx = ~buf_idx;
  end

  // Bus request presented in the state being entered; reads always carry zero data.
  always_comb begin
    bus_nx = '0;
    case (state_nx)
      WR_GLOB: begin
        bus_nx.valid = 1'b1;
        bus_nx.addr  = ADDR_GLOB;
        bus_nx.data  = {1'b1, glob_cfg_i};
      end
      WR_SADDR: begin
        bus_nx.valid = 1'b1;
        bus_nx.addr  = ADDR_SADDR;
        bus_nx.data  = idx_nx ? 32'(buf1_addr_i) : 32'(buf0_addr_i);
      end
      WR_SIZE: begin
        bus_nx.valid = 1'b1;
        bus_nx.addr  = ADDR_SIZE;
        bus_nx.data  = 32'(frame_size_i);
      end
      WR_CFG: begin
        bus_nx.valid = 1'b1;
        bus_nx.addr  = ADDR_CFG;
        bus_nx.data  = {27'd0, 1'b1, 1'b0, datasize_i, 1'b0};
      end
      POLL_RD: begin
        bus_nx.valid = 1'b1;
        bus_nx.rwn   = 1'b1;
        bus_nx.addr  = ADDR_CFG;
      end
      CLR_CFG: begin
        bus_nx.valid = 1'b1;
        bus_nx.addr  = ADDR_CFG;
        bus_nx.data  = 32'h0000_0040;
      end
      DIS_GLOB: begin
        bus_nx.valid = 1'b1;
        bus_nx.addr  = ADDR_GLOB;
        bus_nx.data  = {1'b0, glob_cfg_i};
      end
      default: bus_nx = '0;
    endcase
  end

  // Bus outputs only reload on a state change or an accepted transfer, so a stalled request holds.
  assign bus_load = (state_nx != state) | bus_done;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      buf_idx      <= 1'b0;
      stop_req     <= 1'b0;
      poll_cnt     <= 8'd0;
      cfg_valid_o  <= 1'b0;
      cfg_rwn_o    <= 1'b0;
      cfg_addr_o   <= 5'd0;
      cfg_data_o   <= 32'd0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_buf_o  <= 1'b0;
      frame_cnt_o  <= 8'd0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
    end else begin
      state        <= state_nx;
      buf_idx      <= idx_nx;
      busy_o       <= (state_nx != IDLE);
      frame_done_o <= (state_nx == NEXT);
      done_o       <= (state == DIS_GLOB) && (state_nx == IDLE);

      if (bus_load)
        {cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o} <= bus_nx;

      if (state == IDLE && state_nx == WR_GLOB) begin
        frame_cnt_o <= 8'd0;
        aborted_o   <= 1'b0;
      end else if (state_nx == NEXT) begin
        frame_cnt_o <= frame_cnt_o + 8'd1;
        frame_buf_o <= buf_idx;
      end

      if (state_nx == CLR_CFG && state != CLR_CFG)
        aborted_o <= 1'b1;

      if (state_nx == IDLE)
        stop_req <= 1'b0;
      else if (stop_i && state != IDLE)
        stop_req <= 1'b1;

      if (state_nx == POLL_WAIT && state != POLL_WAIT)
        poll_cnt <= poll_gap_i - 8'd1;
      else if (state == POLL_WAIT && poll_cnt != 8'd0)
        poll_cnt <= poll_cnt - 8'd1;
      else if (state_nx != POLL_WAIT)
        poll_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_camera_frame_seq.sv
// tb/tb_camera_frame_seq.sv - directed self-checking bench for camera_frame_seq
module tb_camera_frame_seq;

  typedef struct {
    logic [4:0]  a;
    logic        r;
    logic [31:0] d;
    int          c;
  } txn_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [30:0] glob_cfg = 31'h1234_5678;
  logic [1:0]  datasize = 2'd0;
  logic [11:0] buf0 = 12'h100;
  logic [11:0] buf1 = 12'h200;
  logic [15:0] frame_size = 16'h0040;
  logic [7:0]  num_frames = 8'd0;
  logic [7:0]  poll_gap = 8'd0;
  logic        rdy = 1'b1;
  logic [31:0] cfg_data_o;
  logic [4:0]  cfg_addr_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic [31:0] cfg_data_i;
  logic        busy_o, frame_done_o, frame_buf_o, done_o, aborted_o;
  logic [7:0]  frame_cnt_o;

  int   cyc = 0;
  int   reads_done = 0;
  int   reads_base = 0;
  int   busy_polls = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  txn_t log_q[$];
  logic fd_q[$];
  logic [7:0] done_q[$];

  localparam logic [31:0] GLOB_EN  = 32'h9234_5678;
  localparam logic [31:0] GLOB_DIS = 32'h1234_5678;

  camera_frame_seq #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .stop_i(stop),
    .glob_cfg_i(glob_cfg), .datasize_i(datasize),
    .buf0_addr_i(buf0), .buf1_addr_i(buf1), .frame_size_i(frame_size),
    .num_frames_i(num_frames), .poll_gap_i(poll_gap),
    .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o),
    .cfg_rwn_o(cfg_rwn_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(rdy),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_buf_o(frame_buf_o),
    .frame_cnt_o(frame_cnt_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;

  assign cfg_data_i = ((reads_done - reads_base) < busy_polls) ? 32'h0000_0010 : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cfg_valid_o && rdy && cfg_rwn_o) reads_done <= reads_done + 1;
  end

  always @(negedge clk) begin
    if (cfg_valid_o && rdy) log_q.push_back('{a: cfg_addr_o, r: cfg_rwn_o, d: cfg_data_o, c: cyc});
    if (frame_done_o) fd_q.push_back(frame_buf_o);
    if (done_o) done_q.push_back(frame_cnt_o);
  end

  function automatic txn_t w(input logic [4:0] a, input logic [31:0] d);
    return '{a: a, r: 1'b0, d: d, c: 0};
  endfunction

  function automatic txn_t rd();
    return '{a: 5'h02, r: 1'b1, d: 32'h0, c: 0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_q.size() > d0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_frame_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (frame_done_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, busy_o, frame_done_o,
         frame_buf_o, frame_cnt_o, done_o, aborted_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%b data=%h busy=%b cnt=%0d aborted=%b exp all 0",
               cfg_valid_o, cfg_data_o, busy_o, frame_cnt_o, aborted_o);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_two_frames();
    txn_t e[$];
    int n0 = log_q.size();
    int f0 = fd_q.size();
    int d0 = done_q.size();
    bit ok;
    num_frames = 8'd2; poll_gap = 8'd0; datasize = 2'd0; busy_polls = 0;
    pulse_start();
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL two_frames_busy got=%b exp=1", busy_o); end
    wait_done(d0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL two_frames_timeout got=no_done exp=done"); end
    e = '{w(5'h08, GLOB_EN), w(5'h00, 32'h100), w(5'h01, 32'h40), w(5'h02, 32'h10), rd(),
          w(5'h00, 32'h200), w(5'h01, 32'h40), w(5'h02, 32'h10), rd(), w(5'h08, GLOB_DIS)};
    n_checks++;
    if (log_q.size() - n0 !== e.size()) begin
      n_fail++; $display("FAIL two_frames_count got=%0d exp=%0d", log_q.size() - n0, e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        n_checks++;
        if (log_q[n0+i].a !== e[i].a || log_q[n0+i].r !== e[i].r || log_q[n0+i].d !== e[i].d) begin
          n_fail++;
          $display("FAIL two_frames_txn%0d got a=%h r=%b d=%h exp a=%h r=%b d=%h", i,
                   log_q[n0+i].a, log_q[n0+i].r, log_q[n0+i].d, e[i].a, e[i].r, e[i].d);
        end
      end
    end
    n_checks++;
    if (fd_q.size() - f0 !== 2 || fd_q[f0] !== 1'b0 || fd_q[f0+1] !== 1'b1) begin
      n_fail++; $display("FAIL two_frames_bufs got n=%0d exp n=2 bufs 0,1", fd_q.size() - f0);
    end
    n_checks++;
    if (frame_cnt_o !== 8'd2 || busy_o !== 1'b0 || aborted_o !== 1'b0) begin
      n_fail++; $display("FAIL two_frames_end got cnt=%0d busy=%b ab=%b exp cnt=2 busy=0 ab=0",
                         frame_cnt_o, busy_o, aborted_o);
    end
  endtask

  task automatic test_stall();
    int n0 = log_q.size();
    int d0 = done_q.size();
    int n_size = 0;
    bit ok = 1'b0;
    num_frames = 8'd1; poll_gap = 8'd0; busy_polls = 0; rdy = 1'b1;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (cfg_valid_o && cfg_addr_o == 5'h01 && !cfg_rwn_o) begin ok = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_find got=no_size_write exp=size_write"); end
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) rdy = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o} !== {1'b1, 1'b0, 5'h01, 32'h40}) begin
        n_fail++;
        $display("FAIL stall_hold%0d got v=%b a=%h d=%h exp v=1 a=01 d=40", k, cfg_valid_o, cfg_addr_o, cfg_data_o);
      end
      step();
    end
    n_checks++;
    if (cfg_addr_o !== 5'h02) begin n_fail++; $display("FAIL stall_next got a=%h exp a=02", cfg_addr_o); end
    wait_done(d0, ok);
    for (int i = n0; i < log_q.size(); i++) if (log_q[i].a == 5'h01) n_size++;
    n_checks++;
    if (!ok || n_size !== 1 || log_q.size() - n0 !== 6) begin
      n_fail++; $display("FAIL stall_accept got size_writes=%0d txns=%0d exp 1 and 6", n_size, log_q.size() - n0);
    end
  endtask

  task automatic test_poll_gap();
    int n0 = log_q.size();
    int d0 = done_q.size();
    bit ok;
    num_frames = 8'd1; poll_gap = 8'd5; busy_polls = 2; reads_base = reads_done;
    pulse_start();
    wait_done(d0, ok);
    n_checks++;
    if (!ok || log_q.size() - n0 !== 8) begin
      n_fail++; $display("FAIL poll_count got=%0d exp=8", log_q.size() - n0);
    end else begin
      for (int i = 4; i < 7; i++) begin
        n_checks++;
        if (log_q[n0+i].r !== 1'b1 || log_q[n0+i].c - log_q[n0+i-1].c !== 6) begin
          n_fail++; $display("FAIL poll_spacing%0d got r=%b gap=%0d exp r=1 gap=6", i,
                             log_q[n0+i].r, log_q[n0+i].c - log_q[n0+i-1].c);
        end
      end
      n_checks++;
      if (log_q[n0+7].d !== GLOB_DIS || frame_cnt_o !== 8'd1) begin
        n_fail++; $display("FAIL poll_end got d=%h cnt=%0d exp d=%h cnt=1", log_q[n0+7].d, frame_cnt_o, GLOB_DIS);
      end
    end
    busy_polls = 0; poll_gap = 8'd0;
  endtask

  task automatic test_stop_poll();
    txn_t e[$];
    int n0 = log_q.size();
    int d0 = done_q.size();
    bit ok;
    num_frames = 8'd0; poll_gap = 8'd3; busy_polls = 0;
    pulse_start();
    wait_frame_done(ok);
    step();
    for (int i = 0; i < 50; i++) begin
      if (cfg_valid_o && cfg_addr_o == 5'h02 && !cfg_rwn_o) break;
      step();
    end
    step();
    n_checks++;
    if (!ok || cfg_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stop_poll_wait got valid=%b frame_ok=%b exp valid=0 frame_ok=1", cfg_valid_o, ok);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if (aborted_o !== 1'b1) begin n_fail++; $display("FAIL stop_poll_abort got=%b exp=1", aborted_o); end
    wait_done(d0, ok);
    e = '{w(5'h08, GLOB_EN), w(5'h00, 32'h100), w(5'h01, 32'h40), w(5'h02, 32'h10), rd(),
          w(5'h00, 32'h200), w(5'h01, 32'h40), w(5'h02, 32'h10), w(5'h02, 32'h40), w(5'h08, GLOB_DIS)};
    n_checks++;
    if (!ok || log_q.size() - n0 !== e.size()) begin
      n_fail++; $display("FAIL stop_poll_count got=%0d exp=%0d", log_q.size() - n0, e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        n_checks++;
        if (log_q[n0+i].a !== e[i].a || log_q[n0+i].r !== e[i].r || log_q[n0+i].d !== e[i].d) begin
          n_fail++;
          $display("FAIL stop_poll_txn%0d got a=%h r=%b d=%h exp a=%h r=%b d=%h", i,
                   log_q[n0+i].a, log_q[n0+i].r, log_q[n0+i].d, e[i].a, e[i].r, e[i].d);
        end
      end
    end
    n_checks++;
    if (frame_cnt_o !== 8'd1 || aborted_o !== 1'b1 || busy_o !== 1'b0 || done_q[done_q.size()-1] !== 8'd1) begin
      n_fail++; $display("FAIL stop_poll_end got cnt=%0d ab=%b busy=%b exp cnt=1 ab=1 busy=0",
                         frame_cnt_o, aborted_o, busy_o);
    end
    poll_gap = 8'd0;
  endtask

  task automatic test_back_to_back();
    txn_t e[$];
    int n0 = log_q.size();
    int d0 = done_q.size();
    bit ok;
    num_frames = 8'd1; datasize = 2'd3;
    pulse_start();
    n_checks++;
    if (aborted_o !== 1'b0 || frame_cnt_o !== 8'd0) begin
      n_fail++; $display("FAIL b2b_clear got ab=%b cnt=%0d exp ab=0 cnt=0", aborted_o, frame_cnt_o);
    end
    wait_done(d0, ok);
    e = '{w(5'h08, GLOB_EN), w(5'h00, 32'h100), w(5'h01, 32'h40), w(5'h02, 32'h16), rd(), w(5'h08, GLOB_DIS)};
    n_checks++;
    if (!ok || log_q.size() - n0 !== e.size()) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", log_q.size() - n0, e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        n_checks++;
        if (log_q[n0+i].a !== e[i].a || log_q[n0+i].r !== e[i].r || log_q[n0+i].d !== e[i].d) begin
          n_fail++;
          $display("FAIL b2b_txn%0d got a=%h d=%h exp a=%h d=%h", i, log_q[n0+i].a, log_q[n0+i].d, e[i].a, e[i].d);
        end
      end
    end
    datasize = 2'd0;
  endtask

  task automatic test_stop_next();
    int n0 = log_q.size();
    int f0 = fd_q.size();
    int d0 = done_q.size();
    bit ok;
    num_frames = 8'd2;
    pulse_start();
    wait_frame_done(ok);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(d0, ok);
    n_checks++;
    if (!ok || log_q.size() - n0 !== 7 || fd_q.size() - f0 !== 1) begin
      n_fail++; $display("FAIL stop_next_count got txns=%0d frames=%0d exp 7 and 1", log_q.size() - n0, fd_q.size() - f0);
    end else begin
      n_checks++;
      if (log_q[n0+5].a !== 5'h02 || log_q[n0+5].d !== 32'h40 || log_q[n0+6].d !== GLOB_DIS) begin
        n_fail++; $display("FAIL stop_next_tail got a=%h d=%h d=%h exp a=02 d=40 d=%h",
                           log_q[n0+5].a, log_q[n0+5].d, log_q[n0+6].d, GLOB_DIS);
      end
    end
    n_checks++;
    if (frame_cnt_o !== 8'd1 || aborted_o !== 1'b1) begin
      n_fail++; $display("FAIL stop_next_end got cnt=%0d ab=%b exp cnt=1 ab=1", frame_cnt_o, aborted_o);
    end
  endtask

  task automatic test_start_stop_idle();
    int n0 = log_q.size();
    bit seen_busy = 1'b0;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy_o || cfg_valid_o) seen_busy = 1'b1;
      step();
    end
    n_checks++;
    if (seen_busy !== 1'b0 || log_q.size() !== n0) begin
      n_fail++; $display("FAIL start_stop_idle got busy=%b txns=%0d exp busy=0 txns=0", seen_busy, log_q.size() - n0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    num_frames = 8'd1; busy_polls = 1000; reads_base = reads_done; rdy = 1'b1;
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (cfg_valid_o && cfg_rwn_o) begin ok = 1'b1; break; end
      step();
    end
    rdy = 1'b0;
    step();
    n_checks++;
    if (!ok || cfg_valid_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_read got valid=%b exp=1", cfg_valid_o); end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, busy_o, frame_done_o,
         frame_buf_o, frame_cnt_o, done_o, aborted_o} !== '0) begin
      n_fail++; $display("FAIL reset_mid_async got valid=%b rwn=%b busy=%b exp all 0", cfg_valid_o, cfg_rwn_o, busy_o);
    end
    step();
    rstn = 1'b1; rdy = 1'b1; busy_polls = 0;
    step();
    step();
    n_checks++;
    if (busy_o !== 1'b0 || cfg_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle got busy=%b valid=%b exp 0 0", busy_o, cfg_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_stall();
    test_poll_gap();
    test_stop_poll();
    test_back_to_back();
    test_stop_next();
    test_start_stop_idle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
